ofmap_bank_mem: RTL and testbench
=================================

Name: ofmap_bank_mem

Overview:
- Parametrised output-feature-map buffer: NUM_BANKS independent simple-dual-port banks sharing one write address and one read address.
- Adds per-bank write enables and an accumulate mode. Accumulate is a read-modify-write that adds incoming partial sums lane-wise into the stored data, with saturation.
- Sits between the PE array drain path (write side) and the ofmap writeback/DMA path (read side).

Parameters:
- NUM_BANKS, 4, number of banks.
- BANK_W, 128, data bits per bank.
- LANE_W, 16, signed lane width for accumulate; BANK_W must be a multiple of LANE_W.
- DEPTH, 1024, entries per bank.
- ADDR_W, $clog2(DEPTH), address width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write/accumulate request this cycle
- wr_mode  in  1  0 = overwrite, 1 = accumulate
- wr_addr  in  ADDR_W  write address
- wr_bank_en  in  NUM_BANKS  per-bank enable; bit b gates bank b
- wr_data  in  NUM_BANKS*BANK_W  bank b occupies bits [b*BANK_W +: BANK_W]
- rd_valid  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  NUM_BANKS*BANK_W  read data, same packing as wr_data
- rd_data_valid  out  1  rd_data is valid
- wr_pending  out  1  a write is in pipeline stage B, uncommitted

Behaviour:
- Reset (async assert, sync deassert) clears rd_data, rd_data_valid, wr_pending, all pipeline registers and the forward register. RAM contents are not reset.
- Write pipeline, two stages. Every write request, overwrite or accumulate, uses both stages so ordering is preserved.
  - Stage A (cycle T, wr_valid=1): capture mode, addr, bank_en and data. Issue the RAM read of wr_addr in every enabled bank.
  - Stage B (cycle T+1): compute the new word per enabled bank and commit it at the T+1 clock edge. wr_pending=1 during T+1.
  - Overwrite: new = wr_data.
  - Accumulate: new lane i = sat(old lane i + data lane i), with signed LANE_W saturation to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
  - Disabled banks are never written and keep their contents.
- Hazard forwarding. The forward register holds {addr, bank_en, data} of the most recent commit.
  - Case 1: the stage-B op is an accumulate and the op one ahead of it committed last cycle to the same addr. Use the forward-register data as "old" for every bank enabled in that previous op.
  - Case 2: the stage-B op follows a commit made in the same cycle it was in stage A. Use the same rule.
  - Result: back-to-back accumulates to one address every cycle sum correctly.
  - Banks not enabled in the previous op use RAM data.
- Read path.
  - Latency 1: rd_valid at T gives rd_data and rd_data_valid=1 at T+1.
  - rd_valid=0 at T gives rd_data_valid=0 at T+1, and rd_data holds its last value.
  - Read and commit to the same address in the same cycle: the read returns the old (pre-commit) value. No read forwarding.
  - Reads and writes are fully concurrent; there is no backpressure and no ready signals.
- Boundaries.
  - Addresses ≥ DEPTH (non-power-of-2 DEPTH): the write is dropped and the read returns 0.
  - wr_valid with wr_bank_en=0: pipeline slot is consumed, nothing is written, wr_pending still pulses.
  - Reset mid-operation: an op in stage B is discarded and not committed.
  - Saturation applies per lane independently; no cross-lane carry.

Decomposition:
- Package ofmap_pkg: LANES_PER_BANK = BANK_W/LANE_W, the wr_mode enum (WR_OVERWRITE, WR_ACCUM), and a function sat_add_lane(a, b).
- Sub-module ofmap_bank: one simple-dual-port synchronous RAM of width BANK_W, depth DEPTH, read-old-data on collision, no reset. Generated NUM_BANKS times.

Test Plan:
- Overwrite then read: write addr 5, all banks, data 0x..01/02/03/04 per bank; read addr 5 at T+2 → rd_data matches and rd_data_valid=1 at T+3.
- Accumulate back-to-back: overwrite addr 7 lanes=10, then 3 consecutive accumulates of lanes=+1 → read gives every lane=13, which proves forwarding.
- Saturation: lane=0x7FF0, accumulate +0x0020 → 0x7FFF; lane=0x8005, accumulate -0x0010 → 0x8000; neighbouring lanes unaffected.
- Bank enables: overwrite addr 3 all banks = 0xAA.., then overwrite with bank_en=4'b0101 = 0x55.. → banks 0 and 2 hold 0x55.., banks 1 and 3 hold 0xAA...
- Read/write collision: commit new value to addr 9 in the same cycle as a read of addr 9 → read returns the old value; the next read returns the new value.
- Reset mid-pipe: assert reset_n=0 while an accumulate is in stage B → no commit to that address; all outputs 0 after reset.

Source files
------------

// File: rtl/ofmap_bank_mem_pkg.sv
// ============================================================================
// Module      : ofmap_pkg
// Description : Shared types, constants and the lane saturating adder for
//               the output-feature-map bank buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ofmap_pkg;

  // Default geometry. sat_add_lane is sized by OFMAP_LANE_W, so the
  // instantiated LANE_W must match it.
  localparam int OFMAP_BANK_W   = 128;
  localparam int OFMAP_LANE_W   = 16;
  localparam int LANES_PER_BANK = OFMAP_BANK_W / OFMAP_LANE_W;

  typedef enum logic {
    WR_OVERWRITE = 1'b0,
    WR_ACCUM     = 1'b1
  } wr_mode_e;

  // Signed add of one lane, clamped to the representable range.
  function automatic logic [OFMAP_LANE_W-1:0] sat_add_lane(
    input logic [OFMAP_LANE_W-1:0] a,
    input logic [OFMAP_LANE_W-1:0] b
  );
    logic [OFMAP_LANE_W:0]   sum;
    logic [OFMAP_LANE_W-1:0] res;
    sum = {a[OFMAP_LANE_W-1], a} + {b[OFMAP_LANE_W-1], b};
    // Overflow shows as disagreement between the extended sign and the lane MSB
    if (sum[OFMAP_LANE_W] != sum[OFMAP_LANE_W-1]) begin
      res = sum[OFMAP_LANE_W] ? {1'b1, {(OFMAP_LANE_W-1){1'b0}}}
                              : {1'b0, {(OFMAP_LANE_W-1){1'b1}}};
    end else begin
      res = sum[OFMAP_LANE_W-1:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ofmap_bank_mem_bank.sv
// ============================================================================
// Module      : ofmap_bank
// Description : Simple-dual-port synchronous RAM, one write port and one
//               registered read port. A read colliding with a write returns
//               the pre-write contents. No reset on storage or read data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofmap_bank
  import ofmap_pkg::*;
#(
  parameter int WIDTH  = OFMAP_BANK_W,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Write port; callers only issue in-range addresses
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port; sampling before the write lands gives read-old-data
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ofmap_bank_mem.sv
// ============================================================================
// Module      : ofmap_bank_mem
// Description : Multi-bank output-feature-map buffer with per-bank write
//               enables and a saturating lane-wise accumulate mode. Writes
//               run through a two-stage read-modify-write pipeline with
//               forwarding of the previous commit; reads have latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ofmap_bank_mem
  import ofmap_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = OFMAP_BANK_W,
  parameter int LANE_W    = OFMAP_LANE_W,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        wr_valid,
  input  logic                        wr_mode,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [NUM_BANKS-1:0]        wr_bank_en,
  input  logic [NUM_BANKS*BANK_W-1:0] wr_data,
  input  logic                        rd_valid,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [NUM_BANKS*BANK_W-1:0] rd_data,
  output logic                        rd_data_valid,
  output logic                        wr_pending
);

  localparam int              c_lanes  = BANK_W / LANE_W;
  localparam int              c_data_w = NUM_BANKS * BANK_W;
  localparam logic [ADDR_W:0] c_depth  = (ADDR_W+1)'(DEPTH);

  // Stage B (one cycle after the request)
  logic                 r_b_valid;
  wr_mode_e             r_b_mode;
  logic [ADDR_W-1:0]    r_b_addr;
  logic [NUM_BANKS-1:0] r_b_en;
  logic [c_data_w-1:0]  r_b_data;
  logic                 r_b_in_range;
  logic                 r_b_after_commit;   // a commit landed on our stage-A edge

  // Most recent commit
  logic [ADDR_W-1:0]    r_fwd_addr;
  logic [NUM_BANKS-1:0] r_fwd_en;
  logic [c_data_w-1:0]  r_fwd_data;

  // Read side
  logic                 r_rd_data_valid;
  logic                 r_rd_show;          // last read was in range

  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_fwd_hit;
  logic [c_data_w-1:0]  w_rmw_rdata;
  logic [c_data_w-1:0]  w_ram_rdata;
  logic [c_data_w-1:0]  w_new_data;
  logic [NUM_BANKS-1:0] w_commit;

  assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
  assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);

  // The RAM read for this op was sampled on the same edge that the previous
  // op committed, so that commit is invisible in RAM data and must come from
  // the forward register.
  assign w_fwd_hit = r_b_after_commit && (r_fwd_addr == r_b_addr);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [BANK_W-1:0] w_old;
    logic [BANK_W-1:0] w_sum;
    logic [BANK_W-1:0] w_bank_rmw;
    logic [BANK_W-1:0] w_bank_rd;

    assign w_old = (w_fwd_hit && r_fwd_en[b]) ? r_fwd_data[b*BANK_W +: BANK_W]
                                              : w_bank_rmw;

    for (genvar l = 0; l < c_lanes; l++) begin : g_lane
      assign w_sum[l*LANE_W +: LANE_W] =
        sat_add_lane(w_old[l*LANE_W +: LANE_W],
                     r_b_data[b*BANK_W + l*LANE_W +: LANE_W]);
    end

    assign w_new_data[b*BANK_W +: BANK_W] =
      (r_b_mode == WR_ACCUM) ? w_sum : r_b_data[b*BANK_W +: BANK_W];
    assign w_commit[b]                     = r_b_valid && r_b_in_range && r_b_en[b];
    assign w_rmw_rdata[b*BANK_W +: BANK_W] = w_bank_rmw;
    assign w_ram_rdata[b*BANK_W +: BANK_W] = w_bank_rd;

    // Two copies share the write port so the RMW read never competes with
    // the external read for a port.
    ofmap_bank #(.WIDTH(BANK_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rmw (
      .clk     (clock),
      .i_we    (w_commit[b]),
      .i_waddr (r_b_addr),
      .i_wdata (w_new_data[b*BANK_W +: BANK_W]),
      .i_re    (wr_valid && wr_bank_en[b] && w_wr_in_range),
      .i_raddr (wr_addr),
      .o_rdata (w_bank_rmw)
    );

    ofmap_bank #(.WIDTH(BANK_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd (
      .clk     (clock),
      .i_we    (w_commit[b]),
      .i_waddr (r_b_addr),
      .i_wdata (w_new_data[b*BANK_W +: BANK_W]),
      .i_re    (rd_valid && w_rd_in_range),
      .i_raddr (rd_addr),
      .o_rdata (w_bank_rd)
    );
  end

  // Stage A: capture the request into stage B
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_b_valid        <= 1'b0;
      r_b_mode         <= WR_OVERWRITE;
      r_b_addr         <= '0;
      r_b_en           <= '0;
      r_b_data         <= '0;
      r_b_in_range     <= 1'b0;
      r_b_after_commit <= 1'b0;
    end else begin
      r_b_valid <= wr_valid;
      if (wr_valid) begin
        r_b_mode         <= wr_mode_e'(wr_mode);
        r_b_addr         <= wr_addr;
        r_b_en           <= wr_bank_en;
        r_b_data         <= wr_data;
        r_b_in_range     <= w_wr_in_range;
        r_b_after_commit <= r_b_valid && r_b_in_range;
      end
    end
  end

  // Remember every commit (including all-disabled ones) for forwarding
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fwd_addr <= '0;
      r_fwd_en   <= '0;
      r_fwd_data <= '0;
    end else if (r_b_valid && r_b_in_range) begin
      r_fwd_addr <= r_b_addr;
      r_fwd_en   <= r_b_en;
      r_fwd_data <= w_new_data;
    end
  end

  // Read qualifiers; RAM output holds between reads, masked to 0 after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data_valid <= 1'b0;
      r_rd_show       <= 1'b0;
    end else begin
      r_rd_data_valid <= rd_valid;
      if (rd_valid) begin
        r_rd_show <= w_rd_in_range;
      end
    end
  end

  assign rd_data       = r_rd_show ? w_ram_rdata : '0;
  assign rd_data_valid = r_rd_data_valid;
  assign wr_pending    = r_b_valid;

endmodule

`default_nettype wire

// File: tb/tb_ofmap_bank_mem.sv
// ============================================================================
// Module      : tb_ofmap_bank_mem
// Description : Self-checking bench for ofmap_bank_mem: hand sequences for
//               the multi-cycle corners plus a vector table, read data
//               checked through an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ofmap_bank_mem;

  localparam int NB    = 4;
  localparam int BW    = 128;
  localparam int LW    = 16;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int DW    = NB * BW;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_mode;
  logic [AW-1:0] wr_addr;
  logic [NB-1:0] wr_bank_en;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          wr_pending;

  always #5 clock = ~clock;

  ofmap_bank_mem #(
    .NUM_BANKS(NB), .BANK_W(BW), .LANE_W(LW), .DEPTH(DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .wr_valid      (wr_valid),
    .wr_mode       (wr_mode),
    .wr_addr       (wr_addr),
    .wr_bank_en    (wr_bank_en),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_pending    (wr_pending)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  // Reference memory and the op waiting to commit
  logic [DW-1:0] mm [int];
  logic          p_v = 1'b0;
  logic          p_m;
  logic [AW-1:0] p_a;
  logic [NB-1:0] p_e;
  logic [DW-1:0] p_d;

  typedef struct {
    logic          wv;
    logic          wm;
    logic [AW-1:0] wa;
    logic [NB-1:0] we;
    logic [63:0]   lanes;   // {bank3, bank2, bank1, bank0} lane value
    logic          rv;
    logic [AW-1:0] ra;
    logic          exp_pend;
    logic          exp_rdv;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every lane of bank b takes the 16-bit value l[b*16 +: 16]
  function automatic logic [DW-1:0] rep(input logic [63:0] l);
    logic [DW-1:0] r;
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < BW/LW; i++)
        r[b*BW + i*LW +: LW] = l[b*16 +: 16];
    return r;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (int'(a) >= DEPTH || !mm.exists(int'(a))) return '0;
    return mm[int'(a)];
  endfunction

  task automatic model_commit();
    logic [DW-1:0] old, nw;
    if (p_v && int'(p_a) < DEPTH) begin
      old = model_read(p_a);
      nw  = old;
      for (int b = 0; b < NB; b++)
        if (p_e[b])
          for (int i = 0; i < BW/LW; i++)
            nw[b*BW + i*LW +: LW] = p_m ? sat16(old[b*BW + i*LW +: LW], p_d[b*BW + i*LW +: LW])
                                        : p_d[b*BW + i*LW +: LW];
      mm[int'(p_a)] = nw;
    end
  endtask

  // One clock cycle: drive, predict, advance to just after the edge
  task automatic step(input logic wv, input logic wm, input logic [AW-1:0] wa,
                      input logic [NB-1:0] we, input logic [DW-1:0] wd,
                      input logic rv, input logic [AW-1:0] ra,
                      input logic use_c, input logic [DW-1:0] cexp);
    wr_valid = wv; wr_mode = wm; wr_addr = wa; wr_bank_en = we; wr_data = wd;
    rd_valid = rv; rd_addr = ra;
    if (rv) exp_q.push_back(use_c ? cexp : model_read(ra));
    model_commit();
    p_v = wv; p_m = wm; p_a = wa; p_e = we; p_d = wd;
    @(posedge clock);
    #1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
  endtask

  task automatic wr(input logic m, input logic [AW-1:0] a, input logic [NB-1:0] e, input logic [DW-1:0] d);
    step(1'b1, m, a, e, d, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rdc(input logic [AW-1:0] a, input logic [DW-1:0] ex);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, a, 1'b1, ex);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // Read-data scoreboard
  always @(negedge clock) begin
    if (reset_n && rd_data_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got valid data %h expected none", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_data", rd_data, mon_exp);
      end
    end
  end

  localparam logic [63:0] L_SEQ1 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [DW-1:0] SAT_W = {4{128'h0000_0000_0000_0000_FFFF_0100_8005_7FF0}};
  localparam logic [DW-1:0] SAT_D = {4{128'h0000_0000_0000_0000_0001_0001_FFF0_0020}};
  localparam logic [DW-1:0] SAT_E = {4{128'h0000_0000_0000_0000_0000_0101_8000_7FFF}};

  initial begin
    reset_n = 1'b0;
    wr_valid = 1'b0; wr_mode = 1'b0; wr_addr = '0; wr_bank_en = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0;

    tbl[0]  = '{1'b1, 1'b0, 10'd30,   4'hF, 64'h4444_3333_2222_1111, 1'b0, 10'd0,    1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 10'd31,   4'hF, 64'hFFFE_0005_8100_7000, 1'b1, 10'd5,    1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 10'd31,   4'hF, 64'h0003_7FFF_FF00_1000, 1'b1, 10'd7,    1'b1, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 10'd31,   4'hA, 64'h0001_0001_0001_0001, 1'b1, 10'd30,   1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 10'd30,   4'h0, 64'hDEAD_DEAD_DEAD_DEAD, 1'b1, 10'd31,   1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 10'd1000, 4'hF, 64'h1234_1234_1234_1234, 1'b1, 10'd31,   1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 10'd30,   4'h3, 64'h8000_8000_8000_8000, 1'b1, 10'd1000, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 10'd0,    4'h0, 64'h0,                   1'b1, 10'd30,   1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 10'd0,    4'h0, 64'h0,                   1'b1, 10'd31,   1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 10'd32,   4'hF, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 10'd1000, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 10'd32,   4'hF, 64'h7FFF_7FFF_7FFF_7FFF, 1'b1, 10'd3,    1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 10'd0,    4'h0, 64'h0,                   1'b1, 10'd32,   1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 10'd0,    4'h0, 64'h0,                   1'b1, 10'd31,   1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_rd_data", rd_data, '0);
    check("reset_rd_valid", DW'(rd_data_valid), '0);
    check("reset_wr_pending", DW'(wr_pending), '0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Overwrite then read after the commit
    wr(1'b0, 10'd5, 4'hF, rep(L_SEQ1));
    idle();
    rdc(10'd5, rep(L_SEQ1));
    idle();

    // Back-to-back accumulates on one address
    wr(1'b0, 10'd7, 4'hF, rep({4{16'd10}}));
    wr(1'b1, 10'd7, 4'hF, rep({4{16'd1}}));
    wr(1'b1, 10'd7, 4'hF, rep({4{16'd1}}));
    wr(1'b1, 10'd7, 4'hF, rep({4{16'd1}}));
    idle();
    rdc(10'd7, rep({4{16'd13}}));

    // Per-lane saturation, both directions, no cross-lane carry
    wr(1'b0, 10'd11, 4'hF, SAT_W);
    wr(1'b1, 10'd11, 4'hF, SAT_D);
    idle();
    rdc(10'd11, SAT_E);

    // Bank enables
    wr(1'b0, 10'd3, 4'hF, rep({4{16'hAAAA}}));
    wr(1'b0, 10'd3, 4'b0101, rep({4{16'h5555}}));
    idle();
    rdc(10'd3, rep({16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555}));

    // Read colliding with a commit returns the old word
    wr(1'b0, 10'd9, 4'hF, rep({4{16'h1111}}));
    idle();
    wr(1'b0, 10'd9, 4'hF, rep({4{16'h2222}}));
    rdc(10'd9, rep({4{16'h1111}}));
    rdc(10'd9, rep({4{16'h2222}}));

    // Out-of-range write dropped, read returns zero
    wr(1'b0, 10'd1000, 4'hF, rep({4{16'h7777}}));
    idle();
    rdc(10'd1000, '0);

    // Reset while an accumulate sits in stage B
    wr(1'b0, 10'd20, 4'hF, rep({4{16'h0100}}));
    idle();
    rdc(10'd5, rep(L_SEQ1));
    wr(1'b1, 10'd20, 4'hF, rep({4{16'h0001}}));
    check("pend_stage_b", DW'(wr_pending), DW'(1'b1));
    #2;
    reset_n = 1'b0;
    p_v = 1'b0;
    #1;
    check("midreset_rd_data", rd_data, '0);
    check("midreset_rd_valid", DW'(rd_data_valid), '0);
    check("midreset_wr_pending", DW'(wr_pending), '0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    rdc(10'd20, rep({4{16'h0100}}));
    idle();

    // Vector table; read data predicted by the reference memory
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].wv, tbl[i].wm, tbl[i].wa, tbl[i].we, rep(tbl[i].lanes),
           tbl[i].rv, tbl[i].ra, 1'b0, '0);
      check($sformatf("tbl%0d_wr_pending", i), DW'(wr_pending), DW'(tbl[i].exp_pend));
      check($sformatf("tbl%0d_rd_valid", i), DW'(rd_data_valid), DW'(tbl[i].exp_rdv));
    end
    idle();
    idle();

    check("queue_drained", DW'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
